scsp_midi_tx: RTL

SCSP_MIDI_TX -- requirements
Module: scsp_midi_tx

---
 rtl/scsp_midi_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scsp_midi_tx.sv
// MIDI serial transmitter: small byte FIFO feeding an 8N1 shifter whose bit period
// is DIV ticks of the CE enable. MO idles high; frames run back to back while bytes remain.
module scsp_midi_tx #(
    parameter int DIV   = 722,
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic       MOBUF_WR,
    input  logic [7:0] MOBUF_D,
    output logic       MO,
    output logic       OE,
    output logic       OF,
    output logic       BUSY
);
    // state | meaning
    // IDLE  | line high, waiting for a queued byte on a CE tick
    // START | start bit (MO=0) for DIV ticks
    // DATA  | eight data bits, LSB first, DIV ticks each
    // STOP  | stop bit (MO=1); may chain straight into the next START
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [TW-1:0]   tick;
    logic [2:0]      bitidx;
    logic [7:0]      shreg;
    logic            tick_last;
    logic            pop;
    logic            wr_acc;

    always_comb begin
        tick_last = (tick == TW'(DIV - 1));
        pop       = CE && (count != '0) &&
                    ((state == IDLE) || ((state == STOP) && tick_last));
        // A pop frees a slot in the same cycle, so a full FIFO still takes a write then.
        wr_acc    = MOBUF_WR && ((count != CW'(DEPTH)) || pop);
        count_nxt = count;
        if (wr_acc && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !wr_acc)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (wr_acc && !RST)
            mem[wptr] <= MOBUF_D;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            OE     <= 1'b1;
            OF     <= 1'b0;
            state  <= IDLE;
            tick   <= '0;
            bitidx <= '0;
            shreg  <= '0;
            MO     <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count_nxt;
            OE    <= (count_nxt == '0);
            OF    <= (count_nxt == CW'(DEPTH));

            if (CE) begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            shreg <= mem[rptr];
                            tick  <= '0;
                            state <= START;
                            MO    <= 1'b0;
                            BUSY  <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_last) begin
                            tick   <= '0;
                            bitidx <= '0;
                            state  <= DATA;
                            MO     <= shreg[0];
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_last) begin
                            tick <= '0;
                            if (bitidx == 3'd7) begin
                                state <= STOP;
                                MO    <= 1'b1;
                            end else begin
                                bitidx <= bitidx + 1'b1;
                                shreg  <= {1'b0, shreg[7:1]};
                                MO     <= shreg[1];
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_last) begin
                            tick <= '0;
                            if (pop) begin
                                shreg <= mem[rptr];
                                state <= START;
                                MO    <= 1'b0;
                            end else begin
                                state <= IDLE;
                                MO    <= 1'b1;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        MO    <= 1'b1;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
